r_cpu_ctrl: RTL and testbench

//   Multi-cycle sequencer for the R-type CPU datapath (PC, IR, register file, A/B/F latches, ALU).

---
 rtl/r_cpu_ctrl_if.sv | 28 ++
 rtl/r_cpu_ctrl.sv | 130 +++++++++++++
 tb/tb_r_cpu_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/r_cpu_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : r_cpu_ctrl_if
//  Description : Controller <-> datapath bundle: instruction fields in,
//                datapath write strobes and ALU opcode out.
//  Revision    : 1.0
// ============================================================================
interface r_cpu_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       pc_write;
    logic       ir_write;
    logic       ab_write;
    logic       f_write;
    logic       reg_write;
    logic [2:0] alu_op;

    modport master (
        input  op, funct,
        output pc_write, ir_write, ab_write, f_write, reg_write, alu_op
    );

    modport slave (
        output op, funct,
        input  pc_write, ir_write, ab_write, f_write, reg_write, alu_op
    );
endinterface
`default_nettype wire

// File: rtl/r_cpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : r_cpu_ctrl
//  Description : Multi-cycle IF/ID/EX/WB sequencer with R-type decode,
//                sticky illegal-instruction halt and single-step support.
//  Revision    : 1.0
// ============================================================================
module r_cpu_ctrl #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             run,
    input  wire logic             step,
    r_cpu_ctrl_if.master          bus,
    output logic                  illegal,
    output logic [2:0]            state,
    output logic [CNT_W-1:0]      inst_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_IF   = 3'b001,
        S_ID   = 3'b010,
        S_EX   = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b111
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_next;
    logic               r_step_q;
    logic [2:0]         r_alu_op;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_inst_cnt;

    logic               w_go;
    logic               w_legal;
    logic [2:0]         w_dec_alu;
    logic               w_pc_write;
    logic               w_ir_write;
    logic               w_ab_write;
    logic               w_f_write;
    logic               w_reg_write;

    assign w_go = run | (step & ~r_step_q);

    always_comb begin
        w_legal   = 1'b0;
        w_dec_alu = 3'b000;
        if (bus.op == 6'b000000) begin
            w_legal = 1'b1;
            case (bus.funct)
                6'b100100: w_dec_alu = 3'b000;
                6'b100101: w_dec_alu = 3'b001;
                6'b100110: w_dec_alu = 3'b010;
                6'b100111: w_dec_alu = 3'b011;
                6'b100000: w_dec_alu = 3'b100;
                6'b100010: w_dec_alu = 3'b101;
                6'b101011: w_dec_alu = 3'b110;
                6'b000100: w_dec_alu = 3'b111;
                default:   w_legal   = 1'b0;
            endcase
        end
    end

    // Strobes depend on r_state only, so op/funct changes cannot glitch them.
    always_comb begin
        w_next      = r_state;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_ab_write  = 1'b0;
        w_f_write   = 1'b0;
        w_reg_write = 1'b0;
        case (r_state)
            S_IDLE: if (w_go) w_next = S_IF;
            S_IF: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                w_next     = S_ID;
            end
            S_ID: begin
                w_ab_write = 1'b1;
                w_next     = w_legal ? S_EX : S_HALT;
            end
            S_EX: begin
                w_f_write = 1'b1;
                w_next    = S_WB;
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_next      = run ? S_IF : S_IDLE;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_step_q   <= 1'b0;
            r_alu_op   <= 3'b000;
            r_illegal  <= 1'b0;
            r_inst_cnt <= '0;
        end else begin
            r_state  <= w_next;
            r_step_q <= step;
            if (r_state == S_ID) begin
                if (w_legal) r_alu_op  <= w_dec_alu;
                else         r_illegal <= 1'b1;
            end
            if (r_state == S_WB) r_inst_cnt <= r_inst_cnt + c_cnt_one;
        end
    end

    assign bus.pc_write  = w_pc_write;
    assign bus.ir_write  = w_ir_write;
    assign bus.ab_write  = w_ab_write;
    assign bus.f_write   = w_f_write;
    assign bus.reg_write = w_reg_write;
    assign bus.alu_op    = r_alu_op;
    assign illegal       = r_illegal;
    assign state         = r_state;
    assign inst_cnt      = r_inst_cnt;

endmodule
`default_nettype wire

// File: tb/tb_r_cpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_r_cpu_ctrl
//  Description : Directed self-checking bench for r_cpu_ctrl (4-bit counter build).
//  Revision    : 1.0
// ============================================================================
module tb_r_cpu_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             run;
    logic             step;
    logic             illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] inst_cnt;
    int               n_cmp;
    int               n_err;

    r_cpu_ctrl_if bus ();

    r_cpu_ctrl #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .step     (step),
        .bus      (bus.master),
        .illegal  (illegal),
        .state    (state),
        .inst_cnt (inst_cnt)
    );

    logic [4:0] strb;
    assign strb = {bus.pc_write, bus.ir_write, bus.ab_write, bus.f_write, bus.reg_write};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one cycle and check state plus {pc,ir,ab,f,reg} strobes.
    task automatic cyc(input string tag, input logic [2:0] es, input logic [4:0] eb);
        @(negedge clk);
        chk({tag, "_state"}, 32'(state), 32'(es));
        chk({tag, "_strb"},  32'(strb),  32'(eb));
    endtask

    logic [5:0] f_tab [8];
    logic [2:0] a_tab [8];

    initial begin
        n_cmp = 0;
        n_err = 0;
        f_tab = '{6'b100100, 6'b100101, 6'b100110, 6'b100111,
                  6'b100000, 6'b100010, 6'b101011, 6'b000100};
        a_tab = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
        rst = 1'b1; run = 1'b1; step = 1'b0; bus.op = 6'b0; bus.funct = 6'b0;
        #2 rst = 1'b0;

        // T1: reset held during free run
        repeat (3) @(negedge clk);
        chk("t1_state",   32'(state),       32'd0);
        chk("t1_strb",    32'(strb),        32'd0);
        chk("t1_alu",     32'(bus.alu_op),  32'd0);
        chk("t1_cnt",     32'(inst_cnt),    32'd0);
        chk("t1_illegal", 32'(illegal),     32'd0);

        // T2: free-run ADD x3, run dropped mid third instruction
        bus.funct = 6'b100000;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc("t2_if", 3'd1, 5'b11000);
            cyc("t2_id", 3'd2, 5'b00100);
            if (i == 2) run = 1'b0;
            cyc("t2_ex", 3'd3, 5'b00010);
            chk("t2_alu", 32'(bus.alu_op), 32'd4);
            cyc("t2_wb", 3'd4, 5'b00001);
            chk("t2_cnt_wb", 32'(inst_cnt), 32'(i));
        end
        cyc("t2_idle", 3'd0, 5'b00000);
        chk("t2_cnt", 32'(inst_cnt), 32'd3);

        // T3: step held high -> one instruction only
        step = 1'b1;
        cyc("t3_if", 3'd1, 5'b11000);
        cyc("t3_id", 3'd2, 5'b00100);
        cyc("t3_ex", 3'd3, 5'b00010);
        cyc("t3_wb", 3'd4, 5'b00001);
        repeat (5) cyc("t3_hold", 3'd0, 5'b00000);
        chk("t3_cnt", 32'(inst_cnt), 32'd4);
        step = 1'b0;
        @(negedge clk);
        // step pulse, then a second rising edge during EX is discarded
        step = 1'b1;
        cyc("t3b_if", 3'd1, 5'b11000);
        step = 1'b0;
        cyc("t3b_id", 3'd2, 5'b00100);
        cyc("t3b_ex", 3'd3, 5'b00010);
        step = 1'b1;
        cyc("t3b_wb", 3'd4, 5'b00001);
        cyc("t3b_idle", 3'd0, 5'b00000);
        cyc("t3b_idle2", 3'd0, 5'b00000);
        chk("t3b_cnt", 32'(inst_cnt), 32'd5);
        step = 1'b0;
        @(negedge clk);

        // T4: funct sweep via single-step
        for (int k = 0; k < 8; k++) begin
            bus.funct = f_tab[k];
            step = 1'b1;
            cyc("t4_if", 3'd1, 5'b11000);
            step = 1'b0;
            cyc("t4_id", 3'd2, 5'b00100);
            cyc("t4_ex", 3'd3, 5'b00010);
            chk($sformatf("t4_alu%0d", k), 32'(bus.alu_op), 32'(a_tab[k]));
            cyc("t4_wb", 3'd4, 5'b00001);
            cyc("t4_idle", 3'd0, 5'b00000);
        end
        chk("t4_cnt", 32'(inst_cnt), 32'd13);
        bus.funct = 6'b100001;
        step = 1'b1;
        cyc("t4i_if", 3'd1, 5'b11000);
        step = 1'b0;
        cyc("t4i_id", 3'd2, 5'b00100);
        cyc("t4i_halt", 3'd7, 5'b00000);
        chk("t4i_illegal", 32'(illegal),    32'd1);
        chk("t4i_alu",     32'(bus.alu_op), 32'd7);
        chk("t4i_cnt",     32'(inst_cnt),   32'd13);
        run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step = ~step;
            cyc("t4i_sticky", 3'd7, 5'b00000);
        end
        chk("t4i_illegal2", 32'(illegal), 32'd1);
        rst = 1'b0;
        #1;
        chk("t4r_state",   32'(state),   32'd0);
        chk("t4r_illegal", 32'(illegal), 32'd0);
        chk("t4r_cnt",     32'(inst_cnt), 32'd0);
        run = 1'b0; step = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // T5: non-zero op -> halt without writeback
        bus.op = 6'b000010; bus.funct = 6'b100000;
        step = 1'b1;
        cyc("t5_if", 3'd1, 5'b11000);
        step = 1'b0;
        cyc("t5_id", 3'd2, 5'b00100);
        repeat (4) cyc("t5_halt", 3'd7, 5'b00000);
        chk("t5_illegal", 32'(illegal),    32'd1);
        chk("t5_cnt",     32'(inst_cnt),   32'd0);
        chk("t5_alu",     32'(bus.alu_op), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        bus.op = 6'b0; run = 1'b1; rst = 1'b1;

        // T6: counter wrap, then reset during EX
        repeat (61) @(negedge clk);
        chk("t6_state_pre", 32'(state),    32'd1);
        chk("t6_cnt_pre",   32'(inst_cnt), 32'd15);
        cyc("t6_id", 3'd2, 5'b00100);
        cyc("t6_ex", 3'd3, 5'b00010);
        cyc("t6_wb", 3'd4, 5'b00001);
        chk("t6_cnt_wb", 32'(inst_cnt), 32'd15);
        cyc("t6_if", 3'd1, 5'b11000);
        chk("t6_wrap", 32'(inst_cnt), 32'd0);
        cyc("t6_id2", 3'd2, 5'b00100);
        cyc("t6_ex2", 3'd3, 5'b00010);
        rst = 1'b0;
        #1;
        chk("t6_rst_state", 32'(state), 32'd0);
        chk("t6_rst_strb",  32'(strb),  32'd0);
        repeat (3) cyc("t6_rst", 3'd0, 5'b00000);
        chk("t6_rst_cnt", 32'(inst_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
